// File: rtl/flag_branch_unit.sv
`default_nettype none
// ============================================================================
// Module      : flag_branch_unit
// Description : Flag register, conditional branch evaluator and PC sequencer.
//               Optional macro FLAG_BRANCH_FLAG_FORWARD_EN forwards incoming
//               flags into branch evaluation instead of interlocking.
// Revision    : 1.0 - initial release
// ============================================================================
module flag_branch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        fetch_en,
    input  logic        flag_we,
    input  logic        carry_in,
    input  logic        zero_in,
    input  logic        overflow_in,
    input  logic        sign_in,
    input  logic        br_valid,
    input  logic [3:0]  br_cond,
    input  logic [31:0] br_target,
    output logic        br_ready,
    output logic [31:0] pc,
    output logic        fetch_valid,
    output logic        br_taken
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        EVAL  = 2'd1,
        FLUSH = 2'd2
    } state_t;

    localparam logic [31:0] c_ALIGN_MASK = 32'hFFFF_FFFC;
    localparam logic [31:0] c_PC_STEP    = 32'd4;

    state_t      r_state;
    state_t      w_next_state;
    logic        r_c, r_z, r_v, r_s;
    logic [3:0]  r_cond;
    logic [31:0] r_target;
    logic [31:0] r_pc;
    logic        r_br_taken;

    logic        w_c, w_z, w_v, w_s;
    logic        w_stall;
    logic        w_lt;
    logic        w_cond_true;
    logic        w_redirect;

    // Flags seen by the evaluator: forwarded from the adder, or the
    // registered copy with an interlock while a write is in flight.
    always_comb begin
`ifdef FLAG_BRANCH_FLAG_FORWARD_EN
        w_c     = flag_we ? carry_in    : r_c;
        w_z     = flag_we ? zero_in     : r_z;
        w_v     = flag_we ? overflow_in : r_v;
        w_s     = flag_we ? sign_in     : r_s;
        w_stall = 1'b0;
`else
        w_c     = r_c;
        w_z     = r_z;
        w_v     = r_v;
        w_s     = r_s;
        w_stall = flag_we;
`endif
    end

    always_comb begin
        w_lt        = w_s ^ w_v;
        w_cond_true = 1'b0;
        case (r_cond)
            4'd0:    w_cond_true = 1'b1;
            4'd1:    w_cond_true = w_z;
            4'd2:    w_cond_true = ~w_z;
            4'd3:    w_cond_true = w_c;
            4'd4:    w_cond_true = ~w_c;
            4'd5:    w_cond_true = w_s;
            4'd6:    w_cond_true = ~w_s;
            4'd7:    w_cond_true = w_v;
            4'd8:    w_cond_true = ~w_v;
            4'd9:    w_cond_true = w_lt;
            4'd10:   w_cond_true = ~w_lt;
            4'd11:   w_cond_true = ~w_z & ~w_lt;
            4'd12:   w_cond_true = w_z | w_lt;
            default: w_cond_true = 1'b0;
        endcase
    end

    always_comb begin
        w_next_state = r_state;
        w_redirect   = 1'b0;
        case (r_state)
            IDLE: begin
                if (br_valid) w_next_state = EVAL;
            end
            EVAL: begin
                if (!w_stall) begin
                    if (w_cond_true) begin
                        w_redirect   = 1'b1;
                        w_next_state = FLUSH;
                    end else begin
                        w_next_state = IDLE;
                    end
                end
            end
            FLUSH:   w_next_state = IDLE;
            default: w_next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= IDLE;
            r_pc       <= RESET_PC;
            r_c        <= 1'b0;
            r_z        <= 1'b0;
            r_v        <= 1'b0;
            r_s        <= 1'b0;
            r_cond     <= 4'd0;
            r_target   <= 32'd0;
            r_br_taken <= 1'b0;
        end else begin
            r_state    <= w_next_state;
            r_br_taken <= w_redirect;
            if (flag_we) begin
                r_c <= carry_in;
                r_z <= zero_in;
                r_v <= overflow_in;
                r_s <= sign_in;
            end
            if (r_state == IDLE && br_valid) begin
                r_cond   <= br_cond;
                r_target <= br_target & c_ALIGN_MASK;
            end
            if (w_redirect) begin
                r_pc <= r_target;
            end else if (r_state != FLUSH && fetch_en) begin
                r_pc <= r_pc + c_PC_STEP;
            end
        end
    end

    assign pc          = r_pc;
    assign br_taken    = r_br_taken;
    assign br_ready    = rst | (r_state == IDLE);
    assign fetch_valid = fetch_en & (r_state != FLUSH);

endmodule
`default_nettype wire

// File: tb/tb_flag_branch_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_flag_branch_unit
// Description : Directed vector table, corner sequences and random stimulus
//               against a reference model for flag_branch_unit.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_flag_branch_unit;

    localparam logic [31:0] c_RESET_PC = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        rst, fetch_en, flag_we;
    logic        carry_in, zero_in, overflow_in, sign_in;
    logic        br_valid;
    logic [3:0]  br_cond;
    logic [31:0] br_target;
    logic        br_ready, fetch_valid, br_taken;
    logic [31:0] pc;

    int n_tests = 0;
    int n_fail  = 0;

    flag_branch_unit #(.RESET_PC(c_RESET_PC)) dut (
        .clk(clk), .rst(rst), .fetch_en(fetch_en), .flag_we(flag_we),
        .carry_in(carry_in), .zero_in(zero_in), .overflow_in(overflow_in),
        .sign_in(sign_in), .br_valid(br_valid), .br_cond(br_cond),
        .br_target(br_target), .br_ready(br_ready), .pc(pc),
        .fetch_valid(fetch_valid), .br_taken(br_taken)
    );

    always #5 clk = ~clk;

    // fl = {C, Z, V, S}
    typedef struct {
        logic        rst, fe, fwe;
        logic [3:0]  fl;
        logic        bv;
        logic [3:0]  cond;
        logic [31:0] tgt;
        logic [31:0] e_pc;
        logic        e_fv, e_rdy, e_tk;
    } vec_t;

`ifdef FLAG_BRANCH_FLAG_FORWARD_EN
    localparam bit c_FWD = 1'b1;
`else
    localparam bit c_FWD = 1'b0;
`endif

    // Reference model: architectural view of PC, flags and one pending branch
    bit          m_valid = 0;
    logic [31:0] m_pc;
    bit [3:0]    m_flags;
    bit          m_pending, m_flush, m_taken;
    bit [3:0]    m_cond;
    logic [31:0] m_tgt;

    function automatic bit cond_holds(input bit [3:0] cc, input bit [3:0] f);
        bit c = f[3], z = f[2], v = f[1], s = f[0];
        bit lt = (s != v);
        case (cc)
            4'd0: return 1'b1;   4'd1: return z;      4'd2: return !z;
            4'd3: return c;      4'd4: return !c;     4'd5: return s;
            4'd6: return !s;     4'd7: return v;      4'd8: return !v;
            4'd9: return lt;     4'd10: return !lt;   4'd11: return !z && !lt;
            4'd12: return z || lt;
            default: return 1'b0;
        endcase
    endfunction

    function automatic vec_t mk(input logic r, fe, fwe, input logic [3:0] fl,
                                input logic bv, input logic [3:0] cond,
                                input logic [31:0] tgt, input logic [31:0] e_pc,
                                input logic e_fv, e_rdy, e_tk);
        vec_t v;
        v.rst = r; v.fe = fe; v.fwe = fwe; v.fl = fl; v.bv = bv; v.cond = cond;
        v.tgt = tgt; v.e_pc = e_pc; v.e_fv = e_fv; v.e_rdy = e_rdy; v.e_tk = e_tk;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s @%0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    task automatic model_check();
        if (m_valid) begin
            check("model pc", pc, m_pc);
            check("model br_taken", {31'd0, br_taken}, {31'd0, m_taken});
            check("model fetch_valid", {31'd0, fetch_valid}, {31'd0, fetch_en && !m_flush});
            check("model br_ready", {31'd0, br_ready}, {31'd0, rst || (!m_pending && !m_flush)});
        end
    endtask

    task automatic model_step();
        bit [3:0] f_in = {carry_in, zero_in, overflow_in, sign_in};
        bit [3:0] f_use;
        logic [31:0] adv = fetch_en ? m_pc + 32'd4 : m_pc;
        if (rst) begin
            m_valid = 1; m_pc = c_RESET_PC; m_flags = 0;
            m_pending = 0; m_flush = 0; m_taken = 0;
            return;
        end
        m_taken = 0;
        if (m_flush) begin
            m_flush = 0;
        end else if (m_pending) begin
            f_use = (c_FWD && flag_we) ? f_in : m_flags;
            if (!c_FWD && flag_we) begin
                m_pc = adv;
            end else if (cond_holds(m_cond, f_use)) begin
                m_pc = m_tgt; m_taken = 1; m_flush = 1; m_pending = 0;
            end else begin
                m_pc = adv; m_pending = 0;
            end
        end else begin
            if (br_valid) begin
                m_pending = 1; m_cond = br_cond; m_tgt = {br_target[31:2], 2'b00};
            end
            m_pc = adv;
        end
        if (flag_we) m_flags = f_in;
    endtask

    task automatic apply(input vec_t v);
        @(negedge clk);
        rst = v.rst; fetch_en = v.fe; flag_we = v.fwe;
        {carry_in, zero_in, overflow_in, sign_in} = v.fl;
        br_valid = v.bv; br_cond = v.cond; br_target = v.tgt;
        #1;
        model_check();
    endtask

    task automatic step_edge();
        @(posedge clk);
        model_step();
    endtask

    task automatic check_outs(input string tag, input logic [31:0] e_pc,
                              input logic e_fv, e_rdy, e_tk);
        check({tag, " pc"}, pc, e_pc);
        check({tag, " fetch_valid"}, {31'd0, fetch_valid}, {31'd0, e_fv});
        check({tag, " br_ready"}, {31'd0, br_ready}, {31'd0, e_rdy});
        check({tag, " br_taken"}, {31'd0, br_taken}, {31'd0, e_tk});
    endtask

    vec_t vecs[22];

    initial begin
        vec_t v;
        vecs[0]  = mk(1,1,0,4'h0,0,0,0,            32'h0,        1,1,0);
        vecs[1]  = mk(0,1,0,4'h0,0,0,0,            32'h0,        1,1,0);
        vecs[2]  = mk(0,1,0,4'h0,0,0,0,            32'h4,        1,1,0);
        vecs[3]  = mk(0,1,0,4'h0,0,0,0,            32'h8,        1,1,0);
        vecs[4]  = mk(0,0,0,4'h0,0,0,0,            32'hC,        0,1,0);
        vecs[5]  = mk(0,0,1,4'b0100,0,0,0,         32'hC,        0,1,0);
        vecs[6]  = mk(0,1,0,4'h0,1,1,32'h103,      32'hC,        1,1,0);
        vecs[7]  = mk(0,1,0,4'h0,0,0,0,            32'h10,       1,0,0);
        vecs[8]  = mk(0,1,0,4'h0,0,0,0,            32'h100,      0,0,1);
        vecs[9]  = mk(0,1,0,4'h0,0,0,0,            32'h100,      1,1,0);
        vecs[10] = mk(0,0,1,4'b0011,0,0,0,         32'h104,      0,1,0);
        vecs[11] = mk(0,1,0,4'h0,1,9,32'h200,      32'h104,      1,1,0);
        vecs[12] = mk(0,1,0,4'h0,0,0,0,            32'h108,      1,0,0);
        vecs[13] = mk(0,1,0,4'h0,0,0,0,            32'h10C,      1,1,0);
        vecs[14] = mk(0,0,0,4'h0,1,0,32'hFFFF_FFFE,32'h110,      0,1,0);
        vecs[15] = mk(0,0,0,4'h0,0,0,0,            32'h110,      0,0,0);
        vecs[16] = mk(0,1,0,4'h0,0,0,0,            32'hFFFF_FFFC,0,0,1);
        vecs[17] = mk(0,1,0,4'h0,0,0,0,            32'hFFFF_FFFC,1,1,0);
        vecs[18] = mk(0,1,0,4'h0,0,0,0,            32'h0,        1,1,0);
        vecs[19] = mk(0,0,0,4'h0,1,13,32'h40,      32'h4,        0,1,0);
        vecs[20] = mk(0,0,0,4'h0,0,0,0,            32'h4,        0,0,0);
        vecs[21] = mk(0,0,0,4'h0,0,0,0,            32'h4,        0,1,0);

        // Initial reset cycle (outputs undefined before the first edge)
        apply(mk(1,0,0,0,0,0,0,0,0,0,0));
        step_edge();

        foreach (vecs[i]) begin
            apply(vecs[i]);
            check_outs($sformatf("vec%0d", i), vecs[i].e_pc, vecs[i].e_fv,
                       vecs[i].e_rdy, vecs[i].e_tk);
            step_edge();
        end

        // Flag write during EVAL: forwarded vs interlocked timing
        apply(mk(0,0,0,4'h0,1,1,32'h300,0,0,0,0));
        step_edge();
        apply(mk(0,0,1,4'b0100,0,0,0,0,0,0,0));
        step_edge();
        apply(mk(0,0,0,4'h0,0,0,0,0,0,0,0));
        check_outs("fwd N+2", c_FWD ? 32'h300 : 32'h4, 1'b0, 1'b0, c_FWD);
        step_edge();
        apply(mk(0,0,0,4'h0,0,0,0,0,0,0,0));
        check_outs("fwd N+3", 32'h300, 1'b0, c_FWD, !c_FWD);
        step_edge();
        apply(mk(0,0,0,4'h0,0,0,0,0,0,0,0));
        check_outs("fwd N+4", 32'h300, 1'b0, 1'b1, 1'b0);
        step_edge();

        // Reset during EVAL of a taken branch aborts the redirect
        apply(mk(0,1,0,4'h0,1,0,32'h500,0,0,0,0));
        step_edge();
        apply(mk(1,1,0,4'h0,0,0,0,0,0,0,0));
        check("rst-eval br_ready", {31'd0, br_ready}, 32'd1);
        step_edge();
        apply(mk(0,1,0,4'h0,0,0,0,0,0,0,0));
        check_outs("rst-eval +1", c_RESET_PC, 1'b1, 1'b1, 1'b0);
        step_edge();
        apply(mk(0,0,0,4'h0,0,0,0,0,0,0,0));
        check_outs("rst-eval +2", c_RESET_PC + 32'd4, 1'b0, 1'b1, 1'b0);
        step_edge();

        // Random traffic against the reference model
        for (int k = 0; k < 600; k++) begin
            v = mk($urandom_range(0, 63) == 0, 1'($urandom), $urandom_range(0, 3) == 0,
                   4'($urandom), 1'($urandom), 4'($urandom_range(0, 15)), $urandom,
                   0, 0, 0, 0);
            apply(v);
            step_edge();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/flag_branch_unit.md
FLAG_BRANCH_UNIT -- requirements
Module: flag_branch_unit

Interface
REQ-001 The block SHALL have parameter RESET_PC, default 32'h0000_0000, giving the PC value loaded on reset.
REQ-002 The block SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst, input, 1, reset that is synchronous and active-high.
REQ-004 The block SHALL have port fetch_en, input, 1, advance PC by 4 this cycle when not redirected or flushed.
REQ-005 The block SHALL have port flag_we, input, 1, latch the four flag inputs into the flag register.
REQ-006 The block SHALL have ports carry_in, zero_in, overflow_in, sign_in, each input, 1, flags from the 32-bit adder (Add_Carry, Zero, Add_Overflow, Add_Sign semantics).
REQ-007 The block SHALL have port br_valid, input, 1, branch request present.
REQ-008 The block SHALL have port br_cond, input, 4, branch condition code.
REQ-009 The block SHALL have port br_target, input, 32, branch target address.
REQ-010 The block SHALL have port br_ready, output, 1, branch request accepted when br_valid and br_ready are both high.
REQ-011 The block SHALL have port pc, output, 32, current fetch address.
REQ-012 The block SHALL have port fetch_valid, output, 1, pc is a valid fetch address this cycle.
REQ-013 The block SHALL have port br_taken, output, 1, one-cycle pulse on PC redirect.

Function
REQ-014 The FSM SHALL have states IDLE, EVAL and FLUSH, with br_ready=1 only in IDLE.
REQ-015 In IDLE, on br_valid && br_ready, the block SHALL capture br_cond and br_target and go to EVAL on the next cycle.
REQ-016 The captured target SHALL have bits [1:0] forced to 0.
REQ-017 Condition codes SHALL be: 0 always; 1 EQ Z; 2 NE ~Z; 3 CS C; 4 CC ~C; 5 MI S; 6 PL ~S; 7 VS V; 8 VC ~V; 9 LT S^V; 10 GE ~(S^V); 11 GT ~Z&~(S^V); 12 LE Z|(S^V); 13-15 never.
REQ-018 In EVAL, if the condition is true, the block SHALL set pc to the target, pulse br_taken for 1 cycle, and go to FLUSH.
REQ-019 In EVAL, if the condition is false, the block SHALL return to IDLE with no PC change other than normal fetch_en advance.
REQ-020 FLUSH SHALL last exactly 1 cycle with fetch_valid=0 and pc held, then go to IDLE.
REQ-021 Outside FLUSH, fetch_valid SHALL equal fetch_en.
REQ-022 Outside FLUSH, and when no redirect occurs that cycle, pc SHALL advance to pc+4 when fetch_en=1.
REQ-023 PC addition SHALL be modulo 2^32, so 32'hFFFF_FFFC advances to 32'h0000_0000.
REQ-024 A redirect SHALL override fetch_en advance in the same cycle.
REQ-025 A flag_we cycle SHALL update the flag register regardless of FSM state.
REQ-026 Latency SHALL be: request accept at cycle N, br_taken and new pc visible at cycle N+2 (forwarding enabled, no interlock).

Reset
REQ-027 On rst=1 at a clock edge, the block SHALL set pc=RESET_PC, flags=0, state=IDLE, br_taken=0, and clear captured cond/target.
REQ-028 With rst=1, br_ready SHALL be 1 and fetch_valid SHALL follow fetch_en from the first cycle after reset.
REQ-029 Reset asserted in EVAL or FLUSH SHALL abort the branch with no redirect and no br_taken pulse.

Configuration
REQ-030 The block SHALL support the macro FLAG_BRANCH_FLAG_FORWARD_EN.
REQ-031 With FLAG_BRANCH_FLAG_FORWARD_EN defined, if flag_we=1 in an EVAL cycle, the condition SHALL be evaluated on the incoming flag inputs (forwarded).
REQ-032 With FLAG_BRANCH_FLAG_FORWARD_EN undefined, if flag_we=1 in an EVAL cycle, the block SHALL stay in EVAL one extra cycle (interlock) and evaluate on the updated flag register, delaying br_taken by 1 cycle.

Verification
REQ-033 Bench SHALL cover: reset, then fetch_en=1 for 3 cycles -> pc 0, 4, 8, 12; fetch_valid=1 throughout.
REQ-034 Bench SHALL cover: flags Z=1 latched, BEQ (cond 1) target 32'h0000_0103 -> pc=32'h0000_0100, br_taken 1 cycle, one fetch_valid=0 cycle.
REQ-035 Bench SHALL cover: S=1, V=1, cond 9 (LT) -> not taken; pc continues +4; br_ready back to 1 after 2 cycles.
REQ-036 Bench SHALL cover: flag_we with Z=1 in EVAL cycle, cond 1 -> taken at N+2 with FLAG_BRANCH_FLAG_FORWARD_EN defined, at N+3 without it.
REQ-037 Bench SHALL cover: pc=32'hFFFF_FFFC, fetch_en=1 -> pc=0.
REQ-038 Bench SHALL cover: rst asserted in EVAL of a taken branch -> pc=RESET_PC, br_taken stays 0, state IDLE.
